ternary_shift_pipe: RTL and testbench

//   Three-stage pipelined shifter for the ALU shift path. Consumes base-3 shift digits
//   (ones / threes / nines, each 0..2) from the binary-to-base-3 encoder directly upstream.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_stage3.sv | 36 +++
 rtl/ternary_shift_pipe.sv | 94 +++++++++
 tb/tb_ternary_shift_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the ternary shift pipeline.
// Op codes, illegal digit code and the per-stage record.
package shift_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] DIGIT_ILLEGAL = 2'b11;

  // digits holds the not-yet-applied digits, next one in [1:0]
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [1:0]        op;
    logic [3:0]        digits;
    logic              err;
  } stage_t;

endpackage

// File: rtl/shift_stage3.sv
// Combinational shift by digit*STEP for one base-3 place.
// Ports: data/op/digit/err_prev in; res/err out.
module shift_stage3
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [1:0]       digit,
  input  logic             err_prev,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  logic bad;
  int   n;
  int   r;

  always_comb begin
    bad = (digit == DIGIT_ILLEGAL);
    n   = bad ? 0 : int'(digit) * STEP;
    r   = n % WIDTH;
    res = data;
    err = err_prev | bad;
    unique case (1'b1)
      op == OP_SLL: res = data << n;
      op == OP_SRA: res = WIDTH'($signed(data) >>> n);
      // rotate via a doubled word; r == 0 leaves data
      op == OP_ROR: res = WIDTH'({data, data} >> r);
      default:      err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ternary_shift_pipe.sv
// Three-stage shifter: S1 ones, S2 threes, S3 nines.
// Ports: clk, rst, in_* (valid/ready/data/op/digits), out_* (valid/ready/data/err).
module ternary_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [1:0]       shift_ones,
  input  logic [1:0]       shift_threes,
  input  logic [1:0]       shift_nines,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  if (WIDTH != DATA_W) begin : g_width_chk
    $error("WIDTH must equal shift_pkg::DATA_W");
  end

  stage_t s1, s2, s3;

  logic             ld1, ld2, ld3;
  logic [WIDTH-1:0] d1, d2, d3;
  logic             e1, e2, e3;
  logic             unused_bits;

  // A stage loads when empty or when its occupant moves on
  assign ld3      = !s3.valid | out_ready;
  assign ld2      = !s2.valid | ld3;
  assign ld1      = !s1.valid | ld2;
  assign in_ready = ld1;

  assign out_valid = s3.valid;
  assign out_data  = s3.data;
  assign out_err   = s3.err;

  assign unused_bits = ^{s2.digits[3:2], s3.op, s3.digits};

  shift_stage3 #(.WIDTH(WIDTH), .STEP(1)) u_ones (
    .data     (in_data),
    .op       (in_op),
    .digit    (shift_ones),
    .err_prev (1'b0),
    .res      (d1),
    .err      (e1)
  );

  shift_stage3 #(.WIDTH(WIDTH), .STEP(3)) u_threes (
    .data     (s1.data),
    .op       (s1.op),
    .digit    (s1.digits[1:0]),
    .err_prev (s1.err),
    .res      (d2),
    .err      (e2)
  );

  shift_stage3 #(.WIDTH(WIDTH), .STEP(9)) u_nines (
    .data     (s2.data),
    .op       (s2.op),
    .digit    (s2.digits[1:0]),
    .err_prev (s2.err),
    .res      (d3),
    .err      (e3)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      if (ld1) begin
        s1 <= '{valid: in_valid, data: d1, op: in_op,
                digits: {shift_nines, shift_threes}, err: e1};
      end
      if (ld2) begin
        s2 <= '{valid: s1.valid, data: d2, op: s1.op,
                digits: {2'b00, s1.digits[3:2]}, err: e2};
      end
      if (ld3) begin
        s3 <= '{valid: s2.valid, data: d3, op: s2.op,
                digits: 4'b0000, err: e3};
      end
    end
  end

endmodule

// File: tb/tb_ternary_shift_pipe.sv
// Directed bench for ternary_shift_pipe.
// Hand-computed vectors, expected queue, single check task.
module tb_ternary_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic [1:0]  shift_ones;
  logic [1:0]  shift_threes;
  logic [1:0]  shift_nines;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  ternary_shift_pipe #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_op        (in_op),
    .shift_ones   (shift_ones),
    .shift_threes (shift_threes),
    .shift_nines  (shift_nines),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    logic [1:0]  o, t, n;
    logic [15:0] e;
    logic        err;
  } vec_t;

  vec_t        v [16];
  logic [16:0] expq [$];
  int          outc [$];
  logic [16:0] cur_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_out = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] op, logic [15:0] d,
                              logic [1:0] o, logic [1:0] t,
                              logic [1:0] n, logic [15:0] e,
                              logic err);
    vec_t x;
    x.op = op; x.d = d; x.o = o; x.t = t; x.n = n;
    x.e = e; x.err = err;
    return x;
  endfunction

  task automatic set_vec(int i);
    in_op        = v[i].op;
    in_data      = v[i].d;
    shift_ones   = v[i].o;
    shift_threes = v[i].t;
    shift_nines  = v[i].n;
    cur_exp      = {v[i].err, v[i].e};
  endtask

  // sample at negedge, then advance one clock
  task automatic tick(output bit acc);
    logic [31:0] want;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      want = (expq.size() > 0) ? 32'(expq.pop_front()) : 32'hFFFF_FFFF;
      chk($sformatf("out%0d", n_out), 32'({out_err, out_data}), want);
      outc.push_back(cyc);
      n_out++;
    end
    if (acc) expq.push_back(cur_exp);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic stream(int lo, int hi, output int used);
    bit acc;
    int i;
    i = lo;
    used = 0;
    in_valid = 1'b1;
    while (i < hi && used < 100) begin
      set_vec(i);
      tick(acc);
      if (acc) i++;
      used++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(i), 32'(hi));
  endtask

  task automatic drain();
    bit acc;
    int g;
    g = 0;
    out_ready = 1'b1;
    while (expq.size() > 0 && g < 40) begin
      tick(acc);
      g++;
    end
    chk("drain_empty", 32'(expq.size()), 0);
  endtask

  initial begin
    bit acc;
    int used, lat, n0, i;

    v[0]  = mk(2'b00, 16'h0001, 0, 2, 1, 16'h8000, 0);
    v[1]  = mk(2'b01, 16'h8000, 0, 2, 1, 16'hFFFF, 0);
    v[2]  = mk(2'b10, 16'h1234, 1, 1, 0, 16'h4123, 0);
    v[3]  = mk(2'b10, 16'h00F0, 0, 0, 2, 16'h003C, 0);
    v[4]  = mk(2'b00, 16'h0003, 1, 3, 0, 16'h0006, 1);
    v[5]  = mk(2'b11, 16'hABCD, 0, 0, 0, 16'hABCD, 1);
    v[6]  = mk(2'b00, 16'h00FF, 0, 0, 2, 16'h0000, 0);
    v[7]  = mk(2'b01, 16'h4000, 1, 0, 0, 16'h2000, 0);
    v[8]  = mk(2'b01, 16'h8001, 0, 0, 2, 16'hFFFF, 0);
    v[9]  = mk(2'b10, 16'h8001, 1, 0, 0, 16'hC000, 0);
    v[10] = mk(2'b00, 16'h1234, 0, 0, 0, 16'h1234, 0);
    v[11] = mk(2'b10, 16'h1234, 1, 2, 1, 16'h1234, 0);
    v[12] = mk(2'b01, 16'h7FF0, 0, 1, 0, 16'h0FFE, 0);
    v[13] = mk(2'b00, 16'h0001, 2, 2, 2, 16'h0000, 0);
    v[14] = mk(2'b10, 16'h1234, 2, 2, 1, 16'h091A, 0);
    v[15] = mk(2'b11, 16'h5555, 3, 0, 0, 16'h5555, 1);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_vec(0);
    tick(acc);
    tick(acc);
    rst = 1'b0;
    tick(acc);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // single op latency
    set_vec(0);
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    chk("lat_accept", 32'(acc), 1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick(acc);
      lat++;
    end
    chk("latency", 32'(lat), 3);
    drain();

    // back-to-back
    outc.delete();
    n0 = n_out;
    stream(1, 9, used);
    chk("b2b_cycles", 32'(used), 8);
    drain();
    chk("b2b_count", 32'(n_out - n0), 8);
    chk("b2b_span", 32'(outc[outc.size()-1] - outc[0]), 7);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    i = 9;
    for (int k = 0; k < 6; k++) begin
      set_vec(i);
      tick(acc);
      if (acc) i++;
      if (out_valid) chk("stall_hold", 32'({out_err, out_data}), 32'(expq[0]));
    end
    chk("bp_accepted", 32'(i - 9), 3);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    n0 = n_out;
    stream(i, 16, used);
    drain();
    chk("bp_count", 32'(n_out - n0), 7);

    // reset with ops in flight
    stream(10, 12, used);
    rst = 1'b1;
    tick(acc);
    expq.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    n0 = n_out;
    for (int k = 0; k < 10; k++) tick(acc);
    chk("no_stale", 32'(n_out - n0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
